// File: rtl/sram_bist_pkg.sv
// Shared types and constants for the SRAM built-in self-test engine.
// The inverse pass is enabled by defining SRAM_BIST_INVERSE_PASS_EN.
package sram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_ISSUE,
        ST_W_GAP,
        ST_W_WAIT,
        ST_R_ISSUE,
        ST_R_GAP,
        ST_R_WAIT,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE_COUNT   = 2'd0;
    localparam logic [1:0] MODE_CHECKER = 2'd1;
    localparam logic [1:0] MODE_XOR     = 2'd2;
    localparam logic [1:0] MODE_SEED    = 2'd3;

endpackage

// File: rtl/sram_bist_pattern.sv
// Combinational expected-data generator for the SRAM BIST.
// Produces the pattern word for one address, optionally inverted.
module sram_bist_pattern
    import sram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [1:0]            mode,
    input  logic                  invert,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] addr_ext;
    logic [DATA_WIDTH-1:0] chk_word;
    logic [DATA_WIDTH-1:0] base;

    always_comb begin
        addr_ext = DATA_WIDTH'(addr);
        chk_word = '0;
        // Odd bit positions set gives 0xAAAA for a 16-bit word.
        for (int i = 0; i < DATA_WIDTH; i++) begin
            chk_word[i] = (i % 2) == 1;
        end
        case (mode)
            MODE_COUNT:   base = addr_ext;
            MODE_CHECKER: base = addr[0] ? ~chk_word : chk_word;
            MODE_XOR:     base = addr_ext ^ seed;
            default:      base = seed;
        endcase
        data = base ^ {DATA_WIDTH{invert}};
    end

endmodule

// File: rtl/sram_bist.sv
// SRAM built-in self-test: writes a pattern over 0..ADDR_LAST, reads it back,
// counts mismatches and captures the first failure. SRAM_BIST_INVERSE_PASS_EN adds an inverted pass.
module sram_bist
    import sram_bist_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 18,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ERR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LAST  = {ADDR_WIDTH{1'b1}},
    parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(16'hA5A5)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  error_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_write,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_data_read
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            mode_q, mode_d;
    logic                  inv_q, inv_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [ERR_WIDTH-1:0]  err_q, err_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_data_write_q, mem_data_write_d;
    logic                  mem_write_q, mem_write_d;
    logic                  mem_read_q, mem_read_d;

    logic [DATA_WIDTH-1:0] expected;
    logic                  last_addr;
    logic                  finish_test;

    sram_bist_pattern #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_pattern (
        .addr  (addr_q),
        .mode  (mode_q),
        .invert(inv_q),
        .seed  (SEED),
        .data  (expected)
    );

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        mode_d           = mode_q;
        inv_d            = inv_q;
        busy_d           = busy_q;
        done_d           = done_q;
        err_d            = err_q;
        fail_addr_d      = fail_addr_q;
        fail_data_d      = fail_data_q;
        mem_address_d    = mem_address_q;
        mem_data_write_d = mem_data_write_q;
        mem_write_d      = 1'b0;
        mem_read_d       = 1'b0;
        finish_test      = 1'b0;
        last_addr        = (addr_q == ADDR_LAST);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_W_ISSUE;
                    addr_d      = '0;
                    inv_d       = 1'b0;
                    mode_d      = mode;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    err_d       = '0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                end
            end
            ST_W_ISSUE: begin
                if (mem_ready) begin
                    mem_write_d      = 1'b1;
                    mem_address_d    = addr_q;
                    mem_data_write_d = expected;
                    state_d          = ST_W_GAP;
                end
            end
            ST_W_GAP: state_d = ST_W_WAIT;
            ST_W_WAIT: begin
                if (mem_ready) begin
                    if (last_addr) begin
                        addr_d  = '0;
                        state_d = ST_R_ISSUE;
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = ST_W_ISSUE;
                    end
                end
            end
            ST_R_ISSUE: begin
                if (mem_ready) begin
                    mem_read_d    = 1'b1;
                    mem_address_d = addr_q;
                    state_d       = ST_R_GAP;
                end
            end
            ST_R_GAP: state_d = ST_R_WAIT;
            ST_R_WAIT: begin
                if (mem_ready) begin
                    // The counter never returns to zero once it saturates, so zero marks "no failure yet".
                    if (mem_data_read != expected) begin
                        if (err_q != '1) begin
                            err_d = err_q + ERR_WIDTH'(1);
                        end
                        if (err_q == '0) begin
                            fail_addr_d = addr_q;
                            fail_data_d = mem_data_read;
                        end
                    end
                    if (!last_addr) begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = ST_R_ISSUE;
                    end else begin
`ifdef SRAM_BIST_INVERSE_PASS_EN
                        if (!inv_q) begin
                            inv_d   = 1'b1;
                            addr_d  = '0;
                            state_d = ST_W_ISSUE;
                        end else begin
                            finish_test = 1'b1;
                        end
`else
                        finish_test = 1'b1;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (finish_test) begin
            state_d = ST_DONE;
            addr_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end

        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            addr_q           <= '0;
            mode_q           <= '0;
            inv_q            <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_q            <= '0;
            fail_addr_q      <= '0;
            fail_data_q      <= '0;
            mem_address_q    <= '0;
            mem_data_write_q <= '0;
            mem_write_q      <= 1'b0;
            mem_read_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            mode_q           <= mode_d;
            inv_q            <= inv_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            err_q            <= err_d;
            fail_addr_q      <= fail_addr_d;
            fail_data_q      <= fail_data_d;
            mem_address_q    <= mem_address_d;
            mem_data_write_q <= mem_data_write_d;
            mem_write_q      <= mem_write_d;
            mem_read_q       <= mem_read_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign error_count    = err_q;
    assign fail_addr      = fail_addr_q;
    assign fail_data      = fail_data_q;
    assign mem_address    = mem_address_q;
    assign mem_data_write = mem_data_write_q;
    assign mem_write      = mem_write_q;
    assign mem_read       = mem_read_q;

endmodule

// File: tb/tb_sram_bist.sv
// Self-checking bench for sram_bist with a behavioural SRAM/controller model (2-cycle busy).
// Expectations follow SRAM_BIST_INVERSE_PASS_EN when it is defined.
module tb_sram_bist;

    localparam int AW = 18;
    localparam int DW = 16;
    localparam int N  = 16;
`ifdef SRAM_BIST_INVERSE_PASS_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          busy, done, pass, mem_write, mem_read;
    logic [15:0]   error_count;
    logic [AW-1:0] fail_addr, mem_address;
    logic [DW-1:0] fail_data, mem_data_write;
    logic          mem_ready = 1'b1;
    logic [DW-1:0] mem_data_read = '0;

    logic          start_s = 1'b0;
    logic          busy_s, done_s, pass_s, mem_write_s, mem_read_s;
    logic [2:0]    error_count_s;
    logic [AW-1:0] fail_addr_s, mem_address_s;
    logic [DW-1:0] fail_data_s, mem_data_write_s;
    logic          mem_ready_s = 1'b1;
    logic [DW-1:0] mem_data_read_s = '0;

    int tests = 0;
    int fails = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    int rdy_cnt = 0;
    int rdy_cnt_s = 0;

    logic [DW-1:0]    mem [0:N-1];
    int               f_addr = -2;
    logic [DW-1:0]    f_set = '0;
    logic [DW-1:0]    f_clr = '0;
    logic [AW+DW-1:0] exp_wq[$];
    logic [AW-1:0]    exp_rq[$];
    logic [AW+DW-1:0] e_w;
    logic [AW-1:0]    e_r;

    sram_bist #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_WIDTH(16),
        .ADDR_LAST(18'd15), .SEED(16'hA5A5)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .busy(busy), .done(done), .pass(pass), .error_count(error_count),
        .fail_addr(fail_addr), .fail_data(fail_data),
        .mem_address(mem_address), .mem_data_write(mem_data_write),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_ready(mem_ready), .mem_data_read(mem_data_read)
    );

    sram_bist #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_WIDTH(3),
        .ADDR_LAST(18'd15), .SEED(16'hA5A5)
    ) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .mode(2'd3),
        .busy(busy_s), .done(done_s), .pass(pass_s), .error_count(error_count_s),
        .fail_addr(fail_addr_s), .fail_data(fail_data_s),
        .mem_address(mem_address_s), .mem_data_write(mem_data_write_s),
        .mem_write(mem_write_s), .mem_read(mem_read_s),
        .mem_ready(mem_ready_s), .mem_data_read(mem_data_read_s)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] model_pat(input logic [1:0] m, input int a, input logic inv);
        logic [DW-1:0] v;
        case (m)
            2'd0:    v = DW'(a);
            2'd1:    v = (a % 2 == 1) ? 16'h5555 : 16'hAAAA;
            2'd2:    v = DW'(a) ^ 16'hA5A5;
            default: v = 16'hA5A5;
        endcase
        return inv ? ~v : v;
    endfunction

    function automatic logic [DW-1:0] apply_fault(input int a, input logic [DW-1:0] d);
        if (f_addr == -1 || f_addr == a) return (d | f_set) & ~f_clr;
        return d;
    endfunction

    // SRAM + controller model: ready drops for two cycles after each request.
    always @(posedge clk) begin
        if (reset) begin
            mem_ready <= 1'b1;
            rdy_cnt   <= 0;
        end else if (mem_write) begin
            mem[mem_address[3:0]] <= mem_data_write;
            mem_ready <= 1'b0;
            rdy_cnt   <= 2;
        end else if (mem_read) begin
            mem_data_read <= apply_fault(int'(mem_address[3:0]), mem[mem_address[3:0]]);
            mem_ready <= 1'b0;
            rdy_cnt   <= 2;
        end else if (rdy_cnt == 1) begin
            rdy_cnt   <= 0;
            mem_ready <= 1'b1;
        end else if (rdy_cnt > 1) begin
            rdy_cnt <= rdy_cnt - 1;
        end
    end

    // Second instance sees a data bus stuck at zero.
    always @(posedge clk) begin
        if (reset) begin
            mem_ready_s <= 1'b1;
            rdy_cnt_s   <= 0;
        end else if (mem_write_s || mem_read_s) begin
            mem_ready_s <= 1'b0;
            rdy_cnt_s   <= 2;
        end else if (rdy_cnt_s == 1) begin
            rdy_cnt_s   <= 0;
            mem_ready_s <= 1'b1;
        end else if (rdy_cnt_s > 1) begin
            rdy_cnt_s <= rdy_cnt_s - 1;
        end
    end

    // Scoreboard monitor: every request pulse pops and checks one expected access.
    always @(negedge clk) begin
        if (mem_write === 1'b1) begin
            wr_pulses++;
            tests++;
            if (exp_wq.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_write: addr=%0d data=%h, required no write", mem_address, mem_data_write);
            end else begin
                e_w = exp_wq.pop_front();
                if ({mem_address, mem_data_write} !== e_w)
                    begin
                        fails++;
                        $display("[TB] FAIL write_access: got addr=%0d data=%h, expected addr=%0d data=%h",
                                 mem_address, mem_data_write, e_w[AW+DW-1:DW], e_w[DW-1:0]);
                    end
            end
        end
        if (mem_read === 1'b1) begin
            rd_pulses++;
            tests++;
            if (exp_rq.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_read: addr=%0d, required no read", mem_address);
            end else begin
                e_r = exp_rq.pop_front();
                if (mem_address !== e_r) begin
                    fails++;
                    $display("[TB] FAIL read_access: got addr=%0d, expected addr=%0d", mem_address, e_r);
                end
            end
        end
    end

    task automatic push_expected(input logic [1:0] m);
        for (int p = 0; p < PASSES; p++) begin
            for (int a = 0; a < N; a++) begin
                exp_wq.push_back({AW'(a), model_pat(m, a, p == 1)});
                exp_rq.push_back(AW'(a));
            end
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int c = 0; c < 3000 && done !== 1'b1; c++) @(negedge clk);
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("[TB] FAIL %s_timeout: done=%b, expected 1", name, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        mode  = 2'd3;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, pass, error_count, fail_addr, fail_data, mem_address, mem_data_write, mem_write, mem_read} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %h, expected 0",
                     {busy, done, pass, error_count, fail_addr, fail_data, mem_address, mem_data_write, mem_write, mem_read});
        end
        reset = 1'b0;
        start = 1'b0;
        wr_pulses = 0;
        rd_pulses = 0;
        repeat (10) @(negedge clk);
        tests++;
        if (wr_pulses + rd_pulses !== 0) begin
            fails++;
            $display("[TB] FAIL pulses_after_reset: got %0d, expected 0", wr_pulses + rd_pulses);
        end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL idle_after_reset: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_mode0();
        f_addr = -2;
        wr_pulses = 0;
        rd_pulses = 0;
        push_expected(2'd0);
        applyStimulus(2'd0);
        mode = 2'd2;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mode0_busy: got %b, expected 1", busy);
        end
        wait_done("mode0");
        tests++;
        if (pass !== 1'b1 || error_count !== 16'd0) begin
            fails++;
            $display("[TB] FAIL mode0_result: pass=%b err=%0d, expected 1 0", pass, error_count);
        end
        tests++;
        if (mem[5] !== ((PASSES == 2) ? 16'hFFFA : 16'h0005)) begin
            fails++;
            $display("[TB] FAIL mode0_mem5: got %h, expected %h", mem[5], (PASSES == 2) ? 16'hFFFA : 16'h0005);
        end
        tests++;
        if (wr_pulses !== N * PASSES || rd_pulses !== N * PASSES) begin
            fails++;
            $display("[TB] FAIL mode0_pulses: wr=%0d rd=%0d, expected %0d each", wr_pulses, rd_pulses, N * PASSES);
        end
        tests++;
        if (exp_wq.size() != 0 || exp_rq.size() != 0) begin
            fails++;
            $display("[TB] FAIL mode0_left: w=%0d r=%0d, expected 0 0", exp_wq.size(), exp_rq.size());
        end
    endtask

    task automatic test_mode1_fault();
        f_addr = 7;
        f_set  = 16'h0008;
        f_clr  = 16'h0000;
        push_expected(2'd1);
        applyStimulus(2'd1);
        wait_done("mode1");
        tests++;
        if (error_count !== 16'd1 || pass !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mode1_count: err=%0d pass=%b, expected 1 0", error_count, pass);
        end
        tests++;
        if (fail_addr !== 18'd7 || fail_data !== 16'h555D) begin
            fails++;
            $display("[TB] FAIL mode1_capture: addr=%0d data=%h, expected 7 555d", fail_addr, fail_data);
        end
    endtask

    task automatic test_mode3_stuck();
        f_addr = -1;
        f_set  = 16'h0000;
        f_clr  = 16'h0002;
        push_expected(2'd3);
        applyStimulus(2'd3);
        wait_done("mode3");
        tests++;
        if (error_count !== ((PASSES == 2) ? 16'd16 : 16'd0)) begin
            fails++;
            $display("[TB] FAIL mode3_count: got %0d, expected %0d", error_count, (PASSES == 2) ? 16 : 0);
        end
        tests++;
        if (pass !== ((PASSES == 2) ? 1'b0 : 1'b1)) begin
            fails++;
            $display("[TB] FAIL mode3_pass: got %b, expected %b", pass, PASSES != 2);
        end
        tests++;
        if (fail_addr !== 18'd0 || fail_data !== ((PASSES == 2) ? 16'h5A58 : 16'h0000)) begin
            fails++;
            $display("[TB] FAIL mode3_capture: addr=%0d data=%h, expected 0 %h",
                     fail_addr, fail_data, (PASSES == 2) ? 16'h5A58 : 16'h0000);
        end
        f_addr = -2;
        f_clr  = 16'h0000;
    endtask

    task automatic test_back_to_back();
        f_addr = -2;
        push_expected(2'd2);
        applyStimulus(2'd2);
        repeat (20) @(negedge clk);
        mode = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        mode = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_start");
        tests++;
        if (pass !== 1'b1 || error_count !== 16'd0) begin
            fails++;
            $display("[TB] FAIL ignore_start_result: pass=%b err=%0d, expected 1 0", pass, error_count);
        end
        push_expected(2'd1);
        applyStimulus(2'd1);
        tests++;
        if (done !== 1'b0 || busy !== 1'b1 || pass !== 1'b0) begin
            fails++;
            $display("[TB] FAIL restart_from_done: done=%b busy=%b pass=%b, expected 0 1 0", done, busy, pass);
        end
        wait_done("restart");
        tests++;
        if (pass !== 1'b1 || exp_wq.size() != 0 || exp_rq.size() != 0) begin
            fails++;
            $display("[TB] FAIL restart_result: pass=%b left=%0d, expected 1 0", pass, exp_wq.size() + exp_rq.size());
        end
    endtask

    task automatic test_reset_mid();
        logic hit;
        hit = 1'b0;
        f_addr = 3;
        f_set  = 16'h8000;
        push_expected(2'd0);
        applyStimulus(2'd0);
        for (int c = 0; c < 3000 && !hit; c++) begin
            @(negedge clk);
            hit = (mem_read === 1'b1) && (mem_address == 18'd9);
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("[TB] FAIL reset_mid_reach: read of address 9 seen=%b, expected 1", hit);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({busy, done, pass, error_count, fail_addr, fail_data, mem_address, mem_data_write, mem_write, mem_read} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_mid_outputs: got %h, expected 0",
                     {busy, done, pass, error_count, fail_addr, fail_data, mem_address, mem_data_write, mem_write, mem_read});
        end
        exp_wq.delete();
        exp_rq.delete();
        f_addr = -2;
        f_set  = 16'h0000;
        reset  = 1'b0;
        @(negedge clk);
        push_expected(2'd0);
        applyStimulus(2'd0);
        wait_done("after_reset");
        tests++;
        if (pass !== 1'b1 || error_count !== 16'd0 || exp_wq.size() != 0 || exp_rq.size() != 0) begin
            fails++;
            $display("[TB] FAIL after_reset_result: pass=%b err=%0d, expected 1 0", pass, error_count);
        end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int c = 0; c < 3000 && done_s !== 1'b1; c++) @(negedge clk);
        tests++;
        if (done_s !== 1'b1) begin
            fails++;
            $display("[TB] FAIL saturate_timeout: done=%b, expected 1", done_s);
        end
        tests++;
        if (error_count_s !== 3'd7 || pass_s !== 1'b0) begin
            fails++;
            $display("[TB] FAIL saturate_count: err=%0d pass=%b, expected 7 0", error_count_s, pass_s);
        end
        tests++;
        if (fail_addr_s !== 18'd0 || fail_data_s !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL saturate_capture: addr=%0d data=%h, expected 0 0000", fail_addr_s, fail_data_s);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) mem[i] = '0;
        test_reset();
        test_mode0();
        test_mode1_fault();
        test_mode3_stuck();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
